// File: rtl/acc_bank_ctrl.sv
// -----------------------------------------------------------------------------
// acc_bank_ctrl
//   Bank router and run controller for the matrix accelerator. Steers the host
//   SRAM port (while idle) or the systolic array ports (while running) onto
//   NUM_BANKS single-port-write SRAM banks. It also provides a start-edge FSM,
//   a sticky done flag, host lockout during a run and a run cycle counter.
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   start_req                       host start level (rising edge acts)
//   cfg_*_bank, *_base              bank selection and address offsets
//   host_wr_* / host_rd_*           host write/read port, read data + valid
//   host_err                        1-cycle pulse on illegal start or access
//                                   during a run
//   sa_*                            systolic array control and data
//   bank_*                          flattened per-bank SRAM interface
//   busy, done, cycle_cnt           run status
// -----------------------------------------------------------------------------
module acc_bank_ctrl #(
  parameter int NUM_BANKS = 4,
  parameter int DW        = 32,
  parameter int AW        = 13,
  parameter int CNT_W     = 32,
  localparam int BW       = $clog2(NUM_BANKS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_req,
  input  logic [BW-1:0]           cfg_row_bank,
  input  logic [BW-1:0]           cfg_col_bank,
  input  logic [BW-1:0]           cfg_wb_bank,
  input  logic [BW-1:0]           cfg_host_bank,
  input  logic [AW-1:0]           row_base,
  input  logic [AW-1:0]           col_base,
  input  logic [AW-1:0]           wb_base,
  input  logic [AW-1:0]           rw_base,
  input  logic                    host_wr_en,
  input  logic [AW-1:0]           host_wr_addr,
  input  logic [DW-1:0]           host_wr_data,
  input  logic                    host_rd_en,
  input  logic [AW-1:0]           host_rd_addr,
  output logic [DW-1:0]           host_rd_data,
  output logic                    host_rd_valid,
  output logic                    host_err,
  output logic                    sa_start,
  input  logic                    sa_done,
  input  logic                    sa_ren_n,
  input  logic                    sa_wen_n,
  input  logic [AW-1:0]           sa_raddr_row,
  input  logic [AW-1:0]           sa_raddr_col,
  input  logic [AW-1:0]           sa_waddr,
  input  logic [DW-1:0]           sa_wdata,
  output logic [DW-1:0]           sa_rdata_row,
  output logic [DW-1:0]           sa_rdata_col,
  output logic [NUM_BANKS-1:0]    bank_wsbn,
  output logic [NUM_BANKS-1:0]    bank_csbn,
  output logic [NUM_BANKS*AW-1:0] bank_waddr,
  output logic [NUM_BANKS*AW-1:0] bank_raddr,
  output logic [NUM_BANKS*DW-1:0] bank_wdata,
  input  logic [NUM_BANKS*DW-1:0] bank_rdata,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_W-1:0]        cycle_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic              start_q;
  logic [BW-1:0]     row_q, col_q, wb_q, hbank_q;
  logic              sa_start_q, sa_start_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              rdv_q, rdv_d;
  logic              rd_run_q, rd_run_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DW-1:0]     rd_hold_q;
  logic [DW-1:0]     rd_sel;
  logic              start_edge, cfg_legal, running, accept;
  logic [NUM_BANKS-1:0] wsbn_c, rstb_c;

  // Widened compare so the check stays meaningful when NUM_BANKS is a power of 2.
  function automatic logic idx_ok(input logic [BW-1:0] idx);
    return 32'(idx) < NUM_BANKS;
  endfunction

  assign start_edge = start_req & ~start_q;
  assign running    = (state_q == S_RUN);
  assign cfg_legal  = idx_ok(cfg_row_bank) & idx_ok(cfg_col_bank) &
                      idx_ok(cfg_wb_bank) & idx_ok(cfg_host_bank) &
                      (cfg_row_bank != cfg_col_bank) &
                      (cfg_row_bank != cfg_wb_bank) &
                      (cfg_col_bank != cfg_wb_bank);
  assign accept     = ~running & start_edge & cfg_legal;

  always_comb begin
    state_d    = state_q;
    sa_start_d = 1'b0;
    done_d     = done_q;
    err_d      = 1'b0;
    cnt_d      = cnt_q;
    rdv_d      = host_rd_en;
    rd_run_d   = running;
    case (state_q)
      S_RUN: begin
        cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        err_d = host_wr_en | host_rd_en;
        if (sa_done) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      default: begin
        if (start_edge) begin
          if (cfg_legal) begin
            state_d    = S_RUN;
            sa_start_d = 1'b1;
            done_d     = 1'b0;
            cnt_d      = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      start_q    <= 1'b0;
      row_q      <= '0;
      col_q      <= '0;
      wb_q       <= '0;
      hbank_q    <= '0;
      sa_start_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rdv_q      <= 1'b0;
      rd_run_q   <= 1'b0;
      cnt_q      <= '0;
      rd_hold_q  <= '0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_req;
      sa_start_q <= sa_start_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rdv_q      <= rdv_d;
      rd_run_q   <= rd_run_d;
      cnt_q      <= cnt_d;
      // Bank indices are frozen for the whole run.
      if (accept) begin
        row_q <= cfg_row_bank;
        col_q <= cfg_col_bank;
        wb_q  <= cfg_wb_bank;
      end
      if (host_rd_en) hbank_q <= cfg_host_bank;
      // Keep the returned word so host_rd_data holds until the next read.
      if (rdv_q) rd_hold_q <= host_rd_data;
    end
  end

  // SRAM data arrives the cycle after the request, so the valid cycle
  // passes the bank output straight through and later cycles use the copy.
  always_comb begin
    rd_sel = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (hbank_q == BW'(b)) rd_sel = bank_rdata[b*DW +: DW];
    end
  end

  assign host_rd_data  = rdv_q ? (rd_run_q ? '0 : rd_sel) : rd_hold_q;
  assign host_rd_valid = rdv_q;
  assign host_err      = err_q;
  assign sa_start      = sa_start_q;
  assign busy          = running;
  assign done          = done_q;
  assign cycle_cnt     = cnt_q;

  always_comb begin
    wsbn_c       = '1;
    rstb_c       = '0;
    bank_waddr   = '0;
    bank_raddr   = '0;
    bank_wdata   = '0;
    sa_rdata_row = '0;
    sa_rdata_col = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (running) begin
        if (row_q == BW'(b)) begin
          bank_raddr[b*AW +: AW] = sa_raddr_row + row_base;
          rstb_c[b]              = ~sa_ren_n;
          sa_rdata_row           = bank_rdata[b*DW +: DW];
        end
        if (col_q == BW'(b)) begin
          bank_raddr[b*AW +: AW] = sa_raddr_col + col_base;
          rstb_c[b]              = ~sa_ren_n;
          sa_rdata_col           = bank_rdata[b*DW +: DW];
        end
        if (wb_q == BW'(b)) begin
          wsbn_c[b]              = sa_wen_n;
          bank_waddr[b*AW +: AW] = sa_waddr + wb_base;
          bank_wdata[b*DW +: DW] = sa_wdata;
        end
      end else if (cfg_host_bank == BW'(b)) begin
        wsbn_c[b]              = ~host_wr_en;
        rstb_c[b]              = host_rd_en;
        bank_waddr[b*AW +: AW] = host_wr_addr + rw_base;
        bank_wdata[b*DW +: DW] = host_wr_data;
        bank_raddr[b*AW +: AW] = host_rd_addr + rw_base;
      end
    end
  end

  assign bank_wsbn = wsbn_c;
  assign bank_csbn = wsbn_c & ~rstb_c;

endmodule

// File: tb/tb_acc_bank_ctrl.sv
module tb_acc_bank_ctrl;
  localparam int N   = 5;
  localparam int DW  = 32;
  localparam int AW  = 13;
  localparam int CW  = 32;
  localparam int BW  = 3;
  localparam int DEP = 8192;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start_req;
  logic [BW-1:0] cfg_row_bank, cfg_col_bank, cfg_wb_bank, cfg_host_bank;
  logic [AW-1:0] row_base, col_base, wb_base, rw_base;
  logic host_wr_en, host_rd_en;
  logic [AW-1:0] host_wr_addr, host_rd_addr;
  logic [DW-1:0] host_wr_data, host_rd_data;
  logic host_rd_valid, host_err, sa_start, sa_done, sa_ren_n, sa_wen_n;
  logic [AW-1:0] sa_raddr_row, sa_raddr_col, sa_waddr;
  logic [DW-1:0] sa_wdata, sa_rdata_row, sa_rdata_col;
  logic [N-1:0] bank_wsbn, bank_csbn;
  logic [N*AW-1:0] bank_waddr, bank_raddr;
  logic [N*DW-1:0] bank_wdata, bank_rdata;
  logic busy, done;
  logic [CW-1:0] cycle_cnt;

  acc_bank_ctrl #(.NUM_BANKS(N), .DW(DW), .AW(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start_req(start_req),
    .cfg_row_bank(cfg_row_bank), .cfg_col_bank(cfg_col_bank),
    .cfg_wb_bank(cfg_wb_bank), .cfg_host_bank(cfg_host_bank),
    .row_base(row_base), .col_base(col_base), .wb_base(wb_base), .rw_base(rw_base),
    .host_wr_en(host_wr_en), .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
    .host_rd_en(host_rd_en), .host_rd_addr(host_rd_addr), .host_rd_data(host_rd_data),
    .host_rd_valid(host_rd_valid), .host_err(host_err), .sa_start(sa_start),
    .sa_done(sa_done), .sa_ren_n(sa_ren_n), .sa_wen_n(sa_wen_n),
    .sa_raddr_row(sa_raddr_row), .sa_raddr_col(sa_raddr_col), .sa_waddr(sa_waddr),
    .sa_wdata(sa_wdata), .sa_rdata_row(sa_rdata_row), .sa_rdata_col(sa_rdata_col),
    .bank_wsbn(bank_wsbn), .bank_csbn(bank_csbn), .bank_waddr(bank_waddr),
    .bank_raddr(bank_raddr), .bank_wdata(bank_wdata), .bank_rdata(bank_rdata),
    .busy(busy), .done(done), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  // SRAM banks: registered read, write on wsbn low.
  bit [DW-1:0] mem [N][DEP];
  bit [DW-1:0] brd [N];
  always @(posedge clk) begin
    for (int b = 0; b < N; b++) begin
      if (!bank_csbn[b]) brd[b] <= mem[b][bank_raddr[b*AW +: AW]];
      if (!bank_wsbn[b]) mem[b][bank_waddr[b*AW +: AW]] <= bank_wdata[b*DW +: DW];
    end
  end
  always_comb begin
    for (int b = 0; b < N; b++) bank_rdata[b*DW +: DW] = brd[b];
  end

  int n_cmp = 0;
  int n_bad = 0;
  int busy_cyc = 0, st_cnt = 0, err_cnt = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model of the controller's observable state.
  bit        m_run, m_done, m_start, m_err, m_rdv, m_prev;
  logic [CW-1:0] m_cnt;
  logic [DW-1:0] m_rdd;
  int        m_row, m_col, m_wb;

  function automatic bit cfg_ok();
    int r = cfg_row_bank, c = cfg_col_bank, w = cfg_wb_bank, h = cfg_host_bank;
    return (r < N) && (c < N) && (w < N) && (h < N) && (r != c) && (r != w) && (c != w);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run <= 0; m_done <= 0; m_start <= 0; m_err <= 0; m_rdv <= 0; m_prev <= 0;
      m_cnt <= 0; m_rdd <= 0; m_row <= 0; m_col <= 0; m_wb <= 0;
    end else begin
      m_prev  <= start_req;
      m_start <= 0;
      m_err   <= 0;
      m_rdv   <= host_rd_en;
      if (m_run) begin
        m_cnt <= (m_cnt == {CW{1'b1}}) ? m_cnt : m_cnt + 1;
        if (host_wr_en || host_rd_en) m_err <= 1;
        if (host_rd_en) m_rdd <= 0;
        if (sa_done) begin m_run <= 0; m_done <= 1; end
      end else begin
        if (host_rd_en)
          m_rdd <= (cfg_host_bank < N) ?
                   mem[cfg_host_bank][(int'(host_rd_addr) + int'(rw_base)) % DEP] : '0;
        if (start_req && !m_prev) begin
          if (cfg_ok()) begin
            m_run <= 1; m_start <= 1; m_done <= 0; m_cnt <= 0;
            m_row <= cfg_row_bank; m_col <= cfg_col_bank; m_wb <= cfg_wb_bank;
          end else m_err <= 1;
        end
      end
    end
  end

  logic [N-1:0] e_ws, e_cs;
  logic [N*AW-1:0] e_wa, e_ra;
  logic [N*DW-1:0] e_wd;
  logic [DW-1:0] e_rr, e_rc;

  always @(negedge clk) begin
    if (chk_en) begin
      e_ws = '1; e_cs = '1; e_wa = '0; e_ra = '0; e_wd = '0; e_rr = '0; e_rc = '0;
      if (m_run) begin
        e_ra[m_row*AW +: AW] = AW'((int'(sa_raddr_row) + int'(row_base)) % DEP);
        e_ra[m_col*AW +: AW] = AW'((int'(sa_raddr_col) + int'(col_base)) % DEP);
        e_cs[m_row] = sa_ren_n;
        e_cs[m_col] = sa_ren_n;
        e_ws[m_wb]  = sa_wen_n;
        e_cs[m_wb]  = sa_wen_n;
        e_wa[m_wb*AW +: AW] = AW'((int'(sa_waddr) + int'(wb_base)) % DEP);
        e_wd[m_wb*DW +: DW] = sa_wdata;
        e_rr = brd[m_row];
        e_rc = brd[m_col];
      end else if (cfg_host_bank < N) begin
        e_ws[cfg_host_bank] = !host_wr_en;
        e_cs[cfg_host_bank] = !host_wr_en && !host_rd_en;
        e_wa[cfg_host_bank*AW +: AW] = AW'((int'(host_wr_addr) + int'(rw_base)) % DEP);
        e_ra[cfg_host_bank*AW +: AW] = AW'((int'(host_rd_addr) + int'(rw_base)) % DEP);
        e_wd[cfg_host_bank*DW +: DW] = host_wr_data;
      end
      chk("busy", busy, m_run);
      chk("done", done, m_done);
      chk("cycle_cnt", cycle_cnt, m_cnt);
      chk("sa_start", sa_start, m_start);
      chk("host_err", host_err, m_err);
      chk("host_rd_valid", host_rd_valid, m_rdv);
      chk("host_rd_data", host_rd_data, m_rdd);
      chk("bank_wsbn", bank_wsbn, e_ws);
      chk("bank_csbn", bank_csbn, e_cs);
      chk("bank_waddr", bank_waddr, e_wa);
      chk("bank_raddr", bank_raddr, e_ra);
      chk("bank_wdata", bank_wdata, e_wd);
      chk("sa_rdata_row", sa_rdata_row, e_rr);
      chk("sa_rdata_col", sa_rdata_col, e_rc);
      if (busy) busy_cyc++;
      if (sa_start) st_cnt++;
      if (host_err) err_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, limit 50000 required");
    $fatal(1);
  end

  initial begin
    start_req = 0; host_wr_en = 0; host_rd_en = 0; sa_done = 0;
    sa_ren_n = 1; sa_wen_n = 1;
    cfg_row_bank = 0; cfg_col_bank = 1; cfg_wb_bank = 3; cfg_host_bank = 0;
    row_base = 0; col_base = 0; wb_base = 0; rw_base = 0;
    host_wr_addr = 0; host_rd_addr = 0; host_wr_data = 0;
    sa_raddr_row = 0; sa_raddr_col = 0; sa_waddr = 0; sa_wdata = 0;
    #1 rst_n = 0;
    chk_en = 1;
    repeat (3) step();
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_cnt", cycle_cnt, 0);
    chk("rst_wsbn", bank_wsbn, {N{1'b1}});
    chk("rst_csbn", bank_csbn, {N{1'b1}});
    rst_n = 1;
    step();

    // T1: host write then read back through rw_base.
    cfg_host_bank = 2; rw_base = 13'h10;
    host_wr_en = 1; host_wr_addr = 5; host_wr_data = 32'hA5A5_0001;
    step();
    host_wr_en = 0; host_rd_en = 1; host_rd_addr = 5;
    step();
    host_rd_en = 0;
    chk("t1_mem", mem[2][13'h15], 32'hA5A5_0001);
    chk("t1_valid", host_rd_valid, 1'b1);
    chk("t1_data", host_rd_data, 32'hA5A5_0001);
    step();
    chk("t1_valid_off", host_rd_valid, 1'b0);
    chk("t1_hold", host_rd_data, 32'hA5A5_0001);

    // Preload bank0[3] for the array read.
    cfg_host_bank = 0; rw_base = 0;
    host_wr_en = 1; host_wr_addr = 3; host_wr_data = 32'h1111_0000;
    step();
    host_wr_en = 0;

    // T2: 20-cycle run, row0 col1 wb3.
    busy_cyc = 0; st_cnt = 0;
    start_req = 1;
    step();
    start_req = 0;
    chk("t2_start", sa_start, 1'b1);
    for (int c = 1; c <= 20; c++) begin
      if (c == 4) chk("t2_rdrow", sa_rdata_row, 32'h1111_0000);
      sa_ren_n = (c == 3) ? 1'b0 : 1'b1;
      sa_raddr_row = 3;
      sa_wen_n = (c == 6) ? 1'b0 : 1'b1;
      sa_waddr = 7; sa_wdata = 32'hDEAD_BEEF;
      sa_done = (c == 20);
      step();
    end
    sa_done = 0; sa_ren_n = 1; sa_wen_n = 1;
    chk("t2_done", done, 1'b1);
    chk("t2_busy_off", busy, 1'b0);
    chk("t2_cnt", cycle_cnt, 20);
    chk("t2_busy_cyc", busy_cyc, 20);
    chk("t2_start_cnt", st_cnt, 1);
    chk("t2_wb_mem", mem[3][7], 32'hDEAD_BEEF);

    // T3: illegal configurations.
    err_cnt = 0; st_cnt = 0;
    cfg_row_bank = 1; cfg_col_bank = 1;
    start_req = 1; step(); start_req = 0;
    chk("t3_err1", host_err, 1'b1);
    step();
    chk("t3_err_pulse", host_err, 1'b0);
    cfg_row_bank = 0; cfg_wb_bank = 3'(N);
    start_req = 1; step(); start_req = 0; step();
    chk("t3_err_cnt", err_cnt, 2);
    chk("t3_no_start", st_cnt, 0);
    chk("t3_idle", busy, 1'b0);
    chk("t3_done_kept", done, 1'b1);
    cfg_wb_bank = 3;

    // T4: host access during a run.
    start_req = 1; step(); start_req = 0;
    cfg_host_bank = 4;
    host_wr_en = 1; host_wr_addr = 9; host_wr_data = 32'h0000_1234;
    host_rd_en = 1; host_rd_addr = 9;
    step();
    host_wr_en = 0; host_rd_en = 0;
    chk("t4_valid", host_rd_valid, 1'b1);
    chk("t4_data0", host_rd_data, 32'h0);
    chk("t4_err", host_err, 1'b1);
    chk("t4_no_write", mem[4][9], 32'h0);
    repeat (3) step();
    sa_done = 1; step(); sa_done = 0;
    chk("t4_done", done, 1'b1);
    chk("t4_cnt", cycle_cnt, 5);
    cfg_host_bank = 0;

    // T5: wb address wrap and held start level.
    wb_base = 13'h1FFF; st_cnt = 0;
    start_req = 1; step();
    sa_wen_n = 0; sa_waddr = 2; sa_wdata = 32'h5555_AAAA;
    #1;
    chk("t5_wrap", bank_waddr[3*AW +: AW], 13'h0001);
    step();
    sa_wen_n = 1;
    repeat (8) step();
    start_req = 0;
    sa_done = 1; step(); sa_done = 0; step();
    chk("t5_single_start", st_cnt, 1);
    chk("t5_mem", mem[3][1], 32'h5555_AAAA);
    chk("t5_done", done, 1'b1);
    wb_base = 0;

    // T6: async reset mid-run, then a fresh run.
    start_req = 1; step(); start_req = 0;
    repeat (4) step();
    #2 rst_n = 0;
    #1;
    chk("t6_busy", busy, 1'b0);
    chk("t6_done", done, 1'b0);
    chk("t6_cnt", cycle_cnt, 0);
    chk("t6_wsbn", bank_wsbn, {N{1'b1}});
    chk("t6_csbn", bank_csbn, {N{1'b1}});
    chk("t6_sa_start", sa_start, 1'b0);
    step();
    rst_n = 1;
    step();
    st_cnt = 0;
    start_req = 1; step(); start_req = 0;
    chk("t6_restart", sa_start, 1'b1);
    chk("t6_busy_on", busy, 1'b1);
    repeat (2) step();
    sa_done = 1; step(); sa_done = 0;
    chk("t6_done2", done, 1'b1);
    chk("t6_cnt2", cycle_cnt, 3);
    step();
    chk("t6_start_cnt", st_cnt, 1);

    repeat (2) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
